// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the UART message arbiter.
package uart_arb_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY, ST_DONE} arb_state_e;

  localparam logic [2:0] BCOUNT_MIN  = 3'd1;
  localparam logic [2:0] BCOUNT_MAX  = 3'd5;
  localparam int         TIMEOUT_DEF = 1023;
  localparam int         IDX_W       = 3;

  function automatic logic bcount_ok(input logic [2:0] bc);
    return (bc >= BCOUNT_MIN) && (bc <= BCOUNT_MAX);
  endfunction
endpackage

// File: rtl/uart_msg_arbiter_if.sv
// Requester and buffer-controller signals of the arbiter; slave is the arbiter side.
interface uart_msg_arbiter_if #(parameter int NREQ = 4);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0][31:0] req_data;
  logic [NREQ-1:0][2:0]  req_bcount;
  logic [NREQ-1:0]       req_grant;
  logic [NREQ-1:0]       req_done;
  logic [NREQ-1:0]       req_err;
  logic                  buf_start;
  logic [31:0]           buf_tbuf;
  logic [2:0]            buf_bcount;
  logic                  buf_ready;
  logic                  busy;

  modport master (
    output req_valid, req_data, req_bcount, buf_ready,
    input  req_grant, req_done, req_err, buf_start, buf_tbuf, buf_bcount, busy
  );
  modport slave (
    input  req_valid, req_data, req_bcount, buf_ready,
    output req_grant, req_done, req_err, buf_start, buf_tbuf, buf_bcount, busy
  );
endinterface

// File: rtl/uart_msg_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request after i_last, wrapping at NREQ.
module rr_pick
  import uart_arb_pkg::*;
#(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]  i_req,
  input  logic [IDX_W-1:0] i_last,
  output logic [NREQ-1:0]  o_gnt,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_vld
);
  logic [7:0]       w_req;
  logic [IDX_W-1:0] w_pos;

  // Request vector is widened to 8 so the 3-bit position indexes it exactly.
  always_comb begin
    w_req = '0;
    w_req[NREQ-1:0] = i_req;
    o_idx = '0;
    o_vld = 1'b0;
    w_pos = i_last;
    for (int k = 0; k < NREQ; k++) begin
      w_pos = (w_pos >= IDX_W'(NREQ-1)) ? '0 : w_pos + 1'b1;
      if (!o_vld && w_req[w_pos]) begin
        o_vld = 1'b1;
        o_idx = w_pos;
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < NREQ; i++) o_gnt[i] = o_vld && (o_idx == IDX_W'(i));
  end
endmodule

// File: rtl/uart_msg_arbiter.sv
// Round-robin arbiter handing one latched message at a time to a UART buffer controller.
module uart_msg_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic               clk,
  input logic               rst_n,
  uart_msg_arbiter_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e       r_state, w_nxt;
  logic [NREQ-1:0]  r_grant, r_done, r_err;
  logic [IDX_W-1:0] r_last, r_own, w_own;
  logic [31:0]      r_tbuf, w_sel_data;
  logic [2:0]       r_bcount, w_sel_bc;
  logic             r_start, r_busy;
  logic [CW-1:0]    r_cnt;
  logic             w_err, w_latch;
  logic [NREQ-1:0]  w_pick, w_own_oh;
  logic [IDX_W-1:0] w_pidx;
  logic             w_pvld;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .i_req  (bus.req_valid),
    .i_last (r_last),
    .o_gnt  (w_pick),
    .o_idx  (w_pidx),
    .o_vld  (w_pvld)
  );

  always_comb begin
    w_sel_data = '0;
    w_sel_bc   = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_pick[i]) begin
        w_sel_data = bus.req_data[i];
        w_sel_bc   = bus.req_bcount[i];
      end
    end
  end

  always_comb begin
    w_nxt   = r_state;
    w_own   = r_own;
    w_err   = 1'b0;
    w_latch = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.buf_ready && w_pvld) begin
          w_latch = 1'b1;
          w_own   = w_pidx;
          // Malformed byte counts never reach the buffer controller.
          if (bcount_ok(w_sel_bc)) w_nxt = ST_ISSUE;
          else begin
            w_nxt = ST_DONE;
            w_err = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (!bus.buf_ready) w_nxt = ST_BUSY;
        else if (r_cnt == CW'(TIMEOUT - 1)) begin
          w_nxt = ST_DONE;
          w_err = 1'b1;
        end
      end
      ST_BUSY: if (bus.buf_ready) w_nxt = ST_DONE;
      ST_DONE: w_nxt = ST_IDLE;
      default: w_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_own_oh = '0;
    for (int i = 0; i < NREQ; i++) w_own_oh[i] = (w_own == IDX_W'(i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_nxt;
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_own    <= '0;
      r_last   <= IDX_W'(NREQ - 1);
      r_tbuf   <= '0;
      r_bcount <= '0;
      r_cnt    <= '0;
      r_start  <= 1'b0;
      r_busy   <= 1'b0;
      r_grant  <= '0;
      r_done   <= '0;
      r_err    <= '0;
    end else begin
      r_own <= w_own;
      if (w_latch) begin
        r_tbuf   <= w_sel_data;
        r_bcount <= w_sel_bc;
      end
      r_cnt   <= (r_state == ST_ISSUE && w_nxt == ST_ISSUE) ? r_cnt + 1'b1 : '0;
      r_start <= (w_nxt == ST_ISSUE);
      r_busy  <= (w_nxt != ST_IDLE);
      r_grant <= (w_nxt == ST_ISSUE || w_nxt == ST_BUSY) ? w_own_oh : '0;
      r_done  <= (w_nxt == ST_DONE) ? w_own_oh : '0;
      r_err   <= (w_nxt == ST_DONE && w_err) ? w_own_oh : '0;
      if (r_state == ST_DONE) r_last <= r_own;
    end
  end

  assign bus.req_grant  = r_grant;
  assign bus.req_done   = r_done;
  assign bus.req_err    = r_err;
  assign bus.buf_start  = r_start;
  assign bus.buf_tbuf   = r_tbuf;
  assign bus.buf_bcount = r_bcount;
  assign bus.busy       = r_busy;
endmodule
